// File: rtl/pe_array_pkg.sv
// Shared constants and the drain-controller state type for the PE-array
// psum readout path.
package pe_array_pkg;

  localparam int DEF_NUM_SETS = 4;
  localparam int DEF_P        = 3;
  localparam int DEF_Q        = 3;
  localparam int DEF_DATA_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } drain_state_e;

  // A degenerate dimension of 1 still needs a 1-bit select/address port.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/psum_skid_fifo.sv
// Two-entry FIFO buffering PE read data ahead of the downstream handshake.
// A push and a pop in the same cycle leave the occupancy unchanged.
module psum_skid_fifo
  import pe_array_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem_q [2];
  logic [DATA_W-1:0] mem_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != 2'd0);
    do_push  = push && ((count_q != 2'd2) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign empty = (count_q == 2'd0);
  assign count = count_q;

endmodule

// File: rtl/psum_drain_ctrl.sv
// Drains every psum of NUM_SETS PE sets (P x Q each) in set/address order
// through a 2-entry FIFO onto a valid/ready stream, tagging the final element.
module psum_drain_ctrl
  import pe_array_pkg::*;
#(
  parameter int NUM_SETS = DEF_NUM_SETS,
  parameter int P        = DEF_P,
  parameter int Q        = DEF_Q,
  parameter int DATA_W   = DEF_DATA_W,
  localparam int SET_W   = clog2_min1(NUM_SETS),
  localparam int ADDR_W  = clog2_min1(P * Q)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pe_rd_en,
  output logic [SET_W-1:0]  pe_set_sel,
  output logic [ADDR_W-1:0] pe_rd_addr,
  input  logic [DATA_W-1:0] pe_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  localparam int ELEMS = P * Q;
  localparam int TOTAL = NUM_SETS * ELEMS;
  localparam int CNT_W = clog2_min1(TOTAL + 1);

  localparam logic [SET_W-1:0]  LAST_SET  = SET_W'(NUM_SETS - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ELEMS - 1);
  localparam logic [CNT_W-1:0]  LAST_XFER = CNT_W'(TOTAL - 1);

  drain_state_e      state_q, state_d;
  logic [SET_W-1:0]  set_q, set_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              inflight_q, inflight_d;
  logic [CNT_W-1:0]  xfer_q, xfer_d;

  logic              fifo_empty;
  logic [1:0]        fifo_count;
  logic              pop;
  logic [2:0]        occ_after;
  logic              last_issue;

  psum_skid_fifo #(
    .DATA_W(DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (inflight_q),
    .din   (pe_rd_data),
    .pop   (pop),
    .dout  (out_data),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Occupancy is judged after this cycle's pop so a free-flowing stream keeps
  // one read in flight behind one buffered entry (1 element/cycle).
  always_comb begin
    pop        = out_valid && out_ready;
    occ_after  = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
    pe_rd_en   = (state_q == ST_READ) && (occ_after < 3'd2);
    last_issue = pe_rd_en && (set_q == LAST_SET) && (addr_q == LAST_ADDR);

    state_d    = state_q;
    set_d      = set_q;
    addr_d     = addr_q;
    inflight_d = pe_rd_en;
    xfer_d     = xfer_q;

    if (pop) begin
      xfer_d = xfer_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_READ;
          set_d   = '0;
          addr_d  = '0;
          xfer_d  = '0;
        end
      end
      ST_READ: begin
        if (pe_rd_en) begin
          if (addr_q == LAST_ADDR) begin
            addr_d = '0;
            set_d  = (set_q == LAST_SET) ? '0 : set_q + 1'b1;
          end else begin
            addr_d = addr_q + 1'b1;
          end
          if (last_issue) begin
            state_d = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        if (fifo_empty && !inflight_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      set_q      <= '0;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      xfer_q     <= '0;
    end else begin
      state_q    <= state_d;
      set_q      <= set_d;
      addr_q     <= addr_d;
      inflight_q <= inflight_d;
      xfer_q     <= xfer_d;
    end
  end

  assign pe_set_sel = set_q;
  assign pe_rd_addr = addr_q;
  assign out_valid  = !fifo_empty;
  assign out_last   = out_valid && (xfer_q == LAST_XFER);
  assign busy       = (state_q == ST_READ) || (state_q == ST_FLUSH);
  assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_psum_drain_ctrl.sv
// Scoreboard bench for psum_drain_ctrl: stimulus queues the expected psum
// stream per pass; a negedge monitor checks reads, transfers and done timing.
module tb_psum_drain_ctrl;

  localparam int NS    = 4;
  localparam int PP    = 3;
  localparam int QQ    = 3;
  localparam int DW    = 16;
  localparam int ELEMS = PP * QQ;
  localparam int TOTAL = NS * ELEMS;

  typedef struct {
    logic [DW-1:0] data;
    bit            last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, pe_rd_en;
  logic [1:0]    pe_set_sel;
  logic [3:0]    pe_rd_addr;
  logic [DW-1:0] pe_rd_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_last;

  logic          start1 = 1'b0;
  logic          busy1, done1, rd1;
  logic [0:0]    set1, addr1;
  logic [DW-1:0] rdata1 = '0;
  logic          ov1;
  logic          ordy1 = 1'b0;
  logic [DW-1:0] od1;
  logic          last1;

  always #5 clk = ~clk;

  psum_drain_ctrl #(
    .NUM_SETS(NS), .P(PP), .Q(QQ), .DATA_W(DW)
  ) u_dut (
    .clk(clk), .rstn(rstn), .start(start), .busy(busy), .done(done),
    .pe_rd_en(pe_rd_en), .pe_set_sel(pe_set_sel), .pe_rd_addr(pe_rd_addr),
    .pe_rd_data(pe_rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
  );

  psum_drain_ctrl #(
    .NUM_SETS(1), .P(1), .Q(1), .DATA_W(DW)
  ) u_dut1 (
    .clk(clk), .rstn(rstn), .start(start1), .busy(busy1), .done(done1),
    .pe_rd_en(rd1), .pe_set_sel(set1), .pe_rd_addr(addr1),
    .pe_rd_data(rdata1), .out_valid(ov1), .out_ready(ordy1),
    .out_data(od1), .out_last(last1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  exp_t          exp_q[$];
  logic [DW-1:0] key = '0;
  logic          rd_n = 1'b0;
  logic [1:0]    set_n = '0;
  logic [3:0]    addr_n = '0;
  logic          rd1_n = 1'b0;

  // PE array models: data for a read appears one cycle after the strobe,
  // otherwise junk so a mistimed capture is visible.
  always @(posedge clk) begin
    #1;
    if (rd_n) pe_rd_data = DW'(int'(set_n) * 16 + int'(addr_n)) ^ key;
    else      pe_rd_data = DW'($urandom);
    if (rd1_n) rdata1 = 16'hA5C3;
    else       rdata1 = DW'($urandom);
  end

  int   cyc = 0;
  int   outstanding = 0;
  int   rd_idx = 0;
  int   xfer_idx = 0;
  int   last_xfer_cyc = -100;
  int   done_cnt = 0;
  logic prev_hold = 1'b0;
  logic prev_done = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always @(negedge clk) begin
    exp_t e;
    int   popi;
    cyc++;
    rd_n   = pe_rd_en;
    set_n  = pe_set_sel;
    addr_n = pe_rd_addr;
    rd1_n  = rd1;
    if (!rstn) begin
      exp_q.delete();
      outstanding = 0;
      rd_idx      = 0;
      xfer_idx    = 0;
      prev_hold   = 1'b0;
      prev_done   = 1'b0;
    end else begin
      popi = (out_valid && out_ready) ? 1 : 0;
      if (prev_hold) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev_data);
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      if (pe_rd_en) begin
        chk("rd_set", pe_set_sel, rd_idx / ELEMS);
        chk("rd_addr", pe_rd_addr, rd_idx % ELEMS);
        chk("rd_room", ((outstanding - popi) < 2) ? 1 : 0, 1);
        rd_idx++;
      end
      if (popi == 1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_xfer", out_data, -1);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_last", out_last, e.last);
          if (e.last) last_xfer_cyc = cyc;
        end
        xfer_idx++;
      end
      outstanding = outstanding + (pe_rd_en ? 1 : 0) - popi;
      if (prev_done) begin
        chk("done_width", done, 0);
        chk("busy_after_done", busy, 0);
      end
      if (done) begin
        chk("done_latency", cyc, last_xfer_cyc + 2);
        chk("reads_per_pass", rd_idx, TOTAL);
        done_cnt++;
        rd_idx   = 0;
        xfer_idx = 0;
      end
      prev_done = done;
    end
  end

  // mode: 0 ready held high, 1 alternating, 2 random, 3 five-cycle stall at element 4
  task automatic run_pass(input int mode, input logic [DW-1:0] k, input bit extra_start);
    int c = 0;
    int hold = 0;
    int d0;
    key = k;
    for (int i = 0; i < TOTAL; i++) begin
      exp_q.push_back('{data: DW'((i / ELEMS) * 16 + (i % ELEMS)) ^ k, last: (i == TOTAL - 1)});
    end
    d0 = done_cnt;
    @(posedge clk); #1;
    start     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("valid_cycle0", out_valid, 0);
    @(posedge clk); #1;
    chk("valid_cycle1", out_valid, 0);
    @(posedge clk); #1;
    chk("valid_cycle2", out_valid, 1);
    while (done_cnt == d0 && c < 600) begin
      case (mode)
        1: out_ready = (c % 2) == 0;
        2: out_ready = 1'($urandom_range(0, 1));
        3: begin
          if (xfer_idx == 4 && hold < 5) begin
            out_ready = 1'b0;
            hold++;
          end else begin
            out_ready = 1'b1;
          end
        end
        default: out_ready = 1'b1;
      endcase
      start = extra_start && (c == 6);
      if (start) chk("busy_at_restart", busy, 1);
      @(posedge clk); #1;
      c++;
    end
    start = 1'b0;
    chk("pass_done", done_cnt - d0, 1);
    chk("queue_drained", exp_q.size(), 0);
    if (mode == 0) chk("throughput_cycles", c, TOTAL + 2);
    if (mode == 3) chk("stall_cycles", hold, 5);
  endtask

  task automatic run_reset_test();
    int c = 0;
    int d0;
    bit found = 0;
    key = '0;
    for (int i = 0; i < TOTAL; i++) begin
      exp_q.push_back('{data: DW'((i / ELEMS) * 16 + (i % ELEMS)), last: (i == TOTAL - 1)});
    end
    d0 = done_cnt;
    @(posedge clk); #1;
    start     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!found && c < 200) begin
      @(negedge clk);
      c++;
      if (pe_rd_en && pe_set_sel == 2'd2 && pe_rd_addr == 4'd5) found = 1;
    end
    chk("reached_set2_addr5", found, 1);
    @(posedge clk); #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", pe_rd_en, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_set", pe_set_sel, 0);
    chk("rst_addr", pe_rd_addr, 0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_no_done", done, 0);
    end
    rstn = 1'b1;
    chk("rst_done_count", done_cnt, d0);
    run_pass(0, 16'h0000, 1'b0);
  endtask

  task automatic run_small();
    int nx = 0;
    int nd = 0;
    int nr = 0;
    int xc = -100;
    ordy1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int c = 1; c <= 20 && nd == 0; c++) begin
      @(negedge clk);
      if (rd1) begin
        chk("small_rd_set", set1, 0);
        chk("small_rd_addr", addr1, 0);
        nr++;
      end
      if (ov1) begin
        chk("small_data", od1, 16'hA5C3);
        chk("small_last", last1, 1);
        xc = c;
        nx++;
      end
      if (done1) begin
        chk("small_done_latency", c - xc, 2);
        nd++;
      end
    end
    chk("small_reads", nr, 1);
    chk("small_xfers", nx, 1);
    chk("small_done", nd, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("init_busy", busy, 0);
    chk("init_done", done, 0);
    chk("init_rd_en", pe_rd_en, 0);
    chk("init_valid", out_valid, 0);
    chk("init_last", out_last, 0);
    chk("init_set", pe_set_sel, 0);
    chk("init_addr", pe_rd_addr, 0);
    rstn = 1'b1;
    @(posedge clk); #1;
    run_pass(0, 16'h0000, 1'b0);
    run_pass(3, DW'($urandom), 1'b0);
    run_pass(1, DW'($urandom), 1'b0);
    run_pass(0, DW'($urandom), 1'b1);
    for (int i = 0; i < 4; i++) begin
      run_pass(2, DW'($urandom), 1'($urandom_range(0, 1)));
    end
    run_reset_test();
    run_small();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
